bus_arbiter: RTL and testbench

//  Two-master arbiter for the SoC data bus ahead of the address-decoding bridge.

---
 rtl/bus_arbiter.sv | 107 ++++++++++
 tb/tb_bus_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with locked bursts capped at MAX_HOLD beats
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mN_req/lock/addr/we/wdata    master N request, burst lock, address, write enable, write data (N=0,1)
//   mN_rdata/gnt/ack             master N read data, grant (registered), beat acknowledge
//   s_addr/we/wdata, s_rdata     shared slave port toward the bridge
// Optional macro BUS_ARB_STATS_EN adds grant_cnt0/grant_cnt1, per-master completed-beat counters.
module bus_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_we,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_gnt,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_we,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_gnt,
   output logic          m1_ack,
   output logic [AW-1:0] s_addr,
   output logic          s_we,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata
`ifdef BUS_ARB_STATS_EN
   ,
   output logic [31:0]   grant_cnt0,
   output logic [31:0]   grant_cnt1
`endif
);
   localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
   state_t state, state_nx;
   logic last, last_nx;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic cur, xreq, xlock, yreq;
   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         last     <= last_nx;
         hold_cnt <= hold_nx;
      end
   // x = current owner, y = the other master
   always_comb begin
      state_nx = state;
      last_nx  = last;
      hold_nx  = hold_cnt;
      cur      = state == GNT1;
      xreq     = cur ? m1_req : m0_req;
      xlock    = cur ? m1_lock : m0_lock;
      yreq     = cur ? m0_req : m1_req;
      if (state == IDLE) begin
         if (m0_req && (!m1_req || last))
            state_nx = GNT0;
         else if (m1_req)
            state_nx = GNT1;
      end else if (xreq && xlock && (hold_cnt < HOLD_TOP || !yreq)) begin
         // saturate while uncontended so a waiting master is served right after the next beat
         hold_nx = hold_cnt == HOLD_TOP ? hold_cnt : hold_cnt + 1'b1;
      end else if (yreq) begin
         state_nx = cur ? GNT0 : GNT1;
         hold_nx  = '0;
         last_nx  = cur;
      end else if (xreq) begin
         hold_nx = '0;
      end else begin
         state_nx = IDLE;
         hold_nx  = '0;
         last_nx  = cur;
      end
   end
   assign m0_gnt   = state == GNT0;
   assign m1_gnt   = state == GNT1;
   assign m0_ack   = m0_gnt & m0_req;
   assign m1_ack   = m1_gnt & m1_req;
   assign s_addr   = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
   assign s_wdata  = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
   // rst gates the write strobe so a beat interrupted by reset never commits
   assign s_we     = !rst & (m0_ack & m0_we | m1_ack & m1_we);
   assign m0_rdata = m0_gnt ? s_rdata : '0;
   assign m1_rdata = m1_gnt ? s_rdata : '0;
`ifdef BUS_ARB_STATS_EN
   always_ff @(posedge clk)
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         grant_cnt0 <= grant_cnt0 + 32'(m0_ack);
         grant_cnt1 <= grant_cnt1 + 32'(m1_ack);
      end
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven self-checking bench for bus_arbiter with an expected-output queue
module tb_bus_arbiter;
   typedef struct {
      logic        rst;
      logic [1:0]  req, lock, we, gnt;
      logic [31:0] a0, a1, d0, d1, srd;
   } vec_t;
   typedef struct packed {
      logic        g0, g1, k0, k1, swe;
      logic [31:0] sa, swd, rd0, rd1;
   } out_t;
   typedef struct {
      out_t        o;
      logic [31:0] c0, c1;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m0_lock = 1'b0, m0_we = 1'b0;
   logic        m1_req = 1'b0, m1_lock = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, s_rdata = '0;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic        m0_gnt, m0_ack, m1_gnt, m1_ack, s_we;
`ifdef BUS_ARB_STATS_EN
   logic [31:0] c0, c1;
`endif

   bus_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack),
      .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_rdata(s_rdata)
`ifdef BUS_ARB_STATS_EN
      , .grant_cnt0(c0), .grant_cnt1(c1)
`endif
   );

   vec_t tbl[$];
   exp_t exp_q[$];
   int tests = 0, fails = 0, idx = 0;
   logic [31:0] cnt0 = '0, cnt1 = '0;

   function automatic vec_t v(logic r, logic [1:0] req, logic [1:0] lock, logic [1:0] we, logic [1:0] gnt);
      vec_t t;
      t.rst  = r;
      t.req  = req;
      t.lock = lock;
      t.we   = we;
      t.gnt  = gnt;
      t.a0   = $urandom;
      t.a1   = $urandom;
      t.d0   = $urandom;
      t.d1   = $urandom;
      t.srd  = $urandom;
      return t;
   endfunction

   task automatic apply(input vec_t t);
      exp_t e;
      @(negedge clk);
      rst = t.rst;
      m0_req = t.req[0]; m0_lock = t.lock[0]; m0_we = t.we[0]; m0_addr = t.a0; m0_wdata = t.d0;
      m1_req = t.req[1]; m1_lock = t.lock[1]; m1_we = t.we[1]; m1_addr = t.a1; m1_wdata = t.d1;
      s_rdata = t.srd;
      e.o.g0  = t.gnt[0];
      e.o.g1  = t.gnt[1];
      e.o.k0  = t.gnt[0] & t.req[0];
      e.o.k1  = t.gnt[1] & t.req[1];
      e.o.swe = !t.rst & (e.o.k0 & t.we[0] | e.o.k1 & t.we[1]);
      e.o.sa  = t.gnt[0] ? t.a0 : t.gnt[1] ? t.a1 : 32'h0;
      e.o.swd = t.gnt[0] ? t.d0 : t.gnt[1] ? t.d1 : 32'h0;
      e.o.rd0 = t.gnt[0] ? t.srd : 32'h0;
      e.o.rd1 = t.gnt[1] ? t.srd : 32'h0;
      e.c0 = cnt0;
      e.c1 = cnt1;
      exp_q.push_back(e);
      cnt0 = t.rst ? 32'h0 : cnt0 + 32'(e.o.k0);
      cnt1 = t.rst ? 32'h0 : cnt1 + 32'(e.o.k1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      out_t act;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         act = {m0_gnt, m1_gnt, m0_ack, m1_ack, s_we, s_addr, s_wdata, m0_rdata, m1_rdata};
         tests++;
         if (act !== e.o) begin
            fails++;
            $display("FAIL vec%0d outputs {gnt0,gnt1,ack0,ack1,we,addr,wdata,rd0,rd1}: got %h want %h", idx, act, e.o);
         end
`ifdef BUS_ARB_STATS_EN
         tests++;
         if ({c0, c1} !== {e.c0, e.c1}) begin
            fails++;
            $display("FAIL vec%0d stats: got %0d/%0d want %0d/%0d", idx, c0, c1, e.c0, e.c1);
         end
`endif
         idx++;
      end
   end

   initial begin
      // reset, two cycles
      tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, 2'b00));
      tbl.push_back(v(1, 2'b00, 2'b00, 2'b00, 2'b00));
      // M0 single write; owner lingers one cycle without ack, then idles
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      tbl.push_back(v(0, 2'b01, 2'b00, 2'b01, 2'b00));
      tbl.push_back(v(0, 2'b01, 2'b00, 2'b01, 2'b01));
      tbl[tbl.size()-1].a0 = 32'h0000_0100;
      tbl[tbl.size()-1].d0 = 32'h0000_00A5;
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      // M1 read
      tbl.push_back(v(0, 2'b10, 2'b00, 2'b00, 2'b00));
      tbl.push_back(v(0, 2'b10, 2'b00, 2'b00, 2'b10));
      tbl[tbl.size()-1].a1  = 32'h0000_2000;
      tbl[tbl.size()-1].srd = 32'hDEAD_BEEF;
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b10));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      // both requesting, unlocked: alternate with no bubble
      for (int i = 0; i < 6; i++)
         tbl.push_back(v(0, 2'b11, 2'b00, 2'($urandom), i == 0 ? 2'b00 : (i % 2 == 1) ? 2'b01 : 2'b10));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b10));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      // M0 locked 6-beat burst, M1 arrives on beat 2: capped at 4 beats
      tbl.push_back(v(0, 2'b01, 2'b01, 2'b01, 2'b00));
      tbl.push_back(v(0, 2'b01, 2'b01, 2'b01, 2'b01));
      for (int i = 0; i < 3; i++) tbl.push_back(v(0, 2'b11, 2'b01, 2'b01, 2'b01));
      tbl.push_back(v(0, 2'b11, 2'b01, 2'b11, 2'b10));
      tbl.push_back(v(0, 2'b01, 2'b01, 2'b01, 2'b01));
      tbl.push_back(v(0, 2'b01, 2'b00, 2'b01, 2'b01));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      // uncontended locked burst saturates hold_cnt; late M1 request yields after one more beat
      tbl.push_back(v(0, 2'b01, 2'b01, 2'b00, 2'b00));
      for (int i = 0; i < 5; i++) tbl.push_back(v(0, 2'b01, 2'b01, 2'b00, 2'b01));
      tbl.push_back(v(0, 2'b11, 2'b01, 2'b00, 2'b01));
      tbl.push_back(v(0, 2'b11, 2'b01, 2'b00, 2'b10));
      tbl.push_back(v(0, 2'b01, 2'b00, 2'b00, 2'b01));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      // tie from IDLE with last=M0 goes to M1
      tbl.push_back(v(0, 2'b11, 2'b00, 2'b00, 2'b00));
      tbl.push_back(v(0, 2'b11, 2'b00, 2'b00, 2'b10));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b01));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      // reset during an M0 locked write beat
      tbl.push_back(v(0, 2'b01, 2'b01, 2'b01, 2'b00));
      tbl.push_back(v(0, 2'b01, 2'b01, 2'b01, 2'b01));
      tbl.push_back(v(1, 2'b01, 2'b01, 2'b01, 2'b01));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      tbl.push_back(v(0, 2'b00, 2'b00, 2'b00, 2'b00));
      foreach (tbl[i]) apply(tbl[i]);
      @(negedge clk);
      @(negedge clk);
      #5;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
